// File: rtl/cmp_stim_checker.sv
// On-chip self-test for a magnitude comparator: sweeps every (a, b) operand pair,
// waits for the comparator to settle, and counts result flags that disagree with a<b / a=b / a>b.
module cmp_stim_checker #(
  parameter int W             = 1,
  parameter int SETTLE_CYCLES = 2,
  parameter int ERR_W         = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  output logic [W-1:0]      o_a,
  output logic [W-1:0]      o_b,
  input  logic              i_yamb,
  input  logic              i_yarb,
  input  logic              i_ya_wieksze_b,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_pass,
  output logic [ERR_W-1:0]  o_err_cnt,
  output logic [2*W-1:0]    o_vec_idx,
  output logic              o_first_err_valid,
  output logic [2*W-1:0]    o_first_err_idx
);

  localparam int VW = 2 * W;
  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  localparam logic [VW-1:0]    VEC_ZERO    = {VW{1'b0}};
  localparam logic [VW-1:0]    VEC_ONE     = VW'(1);
  localparam logic [VW-1:0]    VEC_LAST    = {VW{1'b1}};
  localparam logic [ERR_W-1:0] ERR_ZERO    = {ERR_W{1'b0}};
  localparam logic [ERR_W-1:0] ERR_ONE     = ERR_W'(1);
  localparam logic [ERR_W-1:0] ERR_MAX     = {ERR_W{1'b1}};
  localparam logic [CW-1:0]    CNT_ZERO    = {CW{1'b0}};
  localparam logic [CW-1:0]    CNT_ONE     = CW'(1);
  localparam logic [CW-1:0]    SETTLE_LOAD = CW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t           state_r;
  logic [CW-1:0]    settle_cnt_r;
  logic [VW-1:0]    vec_r;
  logic [ERR_W-1:0] err_cnt_r;
  logic             busy_r;
  logic             done_r;
  logic             pass_r;
  logic             first_valid_r;
  logic [VW-1:0]    first_idx_r;

  logic             mismatch_s;
  logic [ERR_W-1:0] err_next_s;

  // Reference relation {a<b, a==b, a>b} for one vector index, unsigned.
  function automatic logic [2:0] expected_flags(input logic [VW-1:0] v);
    logic [W-1:0] a;
    logic [W-1:0] b;
    a = v[VW-1:W];
    b = v[W-1:0];
    return {a < b, a == b, a > b};
  endfunction

  // Mismatch detection and saturating next error count for the vector under check.
  always_comb begin
    mismatch_s = ({i_yamb, i_yarb, i_ya_wieksze_b} != expected_flags(vec_r));
    err_next_s = err_cnt_r;
    if (mismatch_s && (err_cnt_r != ERR_MAX)) begin
      err_next_s = err_cnt_r + ERR_ONE;
    end else begin
      err_next_s = err_cnt_r;
    end
  end

  // Sweep sequencer; all status outputs are registered here.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r       <= ST_IDLE;
      settle_cnt_r  <= CNT_ZERO;
      vec_r         <= VEC_ZERO;
      err_cnt_r     <= ERR_ZERO;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      pass_r        <= 1'b0;
      first_valid_r <= 1'b0;
      first_idx_r   <= VEC_ZERO;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (i_start) begin
            vec_r         <= VEC_ZERO;
            err_cnt_r     <= ERR_ZERO;
            pass_r        <= 1'b0;
            first_valid_r <= 1'b0;
            first_idx_r   <= VEC_ZERO;
            busy_r        <= 1'b1;
            settle_cnt_r  <= SETTLE_LOAD;
            state_r       <= ST_SETTLE;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_SETTLE: begin
          if (settle_cnt_r == CNT_ZERO) begin
            state_r <= ST_CHECK;
          end else begin
            settle_cnt_r <= settle_cnt_r - CNT_ONE;
          end
        end
        ST_CHECK: begin
          err_cnt_r <= err_next_s;
          if (mismatch_s && !first_valid_r) begin
            first_valid_r <= 1'b1;
            first_idx_r   <= vec_r;
          end else begin
            first_valid_r <= first_valid_r;
          end
          if (vec_r == VEC_LAST) begin
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            pass_r  <= (err_next_s == ERR_ZERO);
            state_r <= ST_DONE;
          end else begin
            vec_r        <= vec_r + VEC_ONE;
            settle_cnt_r <= SETTLE_LOAD;
            state_r      <= ST_SETTLE;
          end
        end
        ST_DONE: begin
          done_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_a               = vec_r[VW-1:W];
  assign o_b               = vec_r[W-1:0];
  assign o_vec_idx         = vec_r;
  assign o_busy            = busy_r;
  assign o_done            = done_r;
  assign o_pass            = pass_r;
  assign o_err_cnt         = err_cnt_r;
  assign o_first_err_valid = first_valid_r;
  assign o_first_err_idx   = first_idx_r;

endmodule
